// File: rtl/matrix_pkg.sv
// matrix_pkg: shared sizes, FSM state type and index width for the 4x4 matrix add/sub unit.
package matrix_pkg;
    localparam int ELEM_W = 16;
    localparam int N_ELEM = 16;
    localparam int MAT_W  = ELEM_W * N_ELEM;
    localparam int IDX_W  = 4;
    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;
endpackage

// File: rtl/addsub_elem.sv
// addsub_elem: one two's-complement element add/sub with wrap-around and signed overflow flag.
module addsub_elem
    import matrix_pkg::*;
#(
    parameter int W = ELEM_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         add,
    output logic [W-1:0] res,
    output logic         ovf
);
    assign res = add ? a + b : a - b;
    // Overflow is only possible when the effective operand signs agree; then the result must keep A's sign.
    assign ovf = (add ? a[W-1] == b[W-1] : a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
endmodule

// File: rtl/matrix_addsub.sv
// matrix_addsub: loads two 4x4 operand matrices and computes A+B or A-B one element per clock
// through a single shared element unit, publishing the whole result at once.
module matrix_addsub #(
    parameter int ELEM_W = 16,
    parameter int N_ELEM = 16
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic [ELEM_W*N_ELEM-1:0] dataIn,
    input  logic                     matDecide,
    input  logic                     add1sub0,
    input  logic                     addRW,
    input  logic                     addEN,
    output logic [ELEM_W*N_ELEM-1:0] dataOut,
    output logic                     addFleg,
    output logic                     ovf,
    output logic                     busy
);
    import matrix_pkg::*;

    state_t                     state, next;
    logic                       en_q, op, full, ovf_sh, elem_ovf, start;
    logic [IDX_W-1:0]           idx;
    logic [ELEM_W*N_ELEM-1:0]   a_reg, b_reg, shadow;
    logic [ELEM_W-1:0]          a_e, b_e, res;

    assign start = addEN & ~en_q;
    assign busy  = state == CALC;
    assign a_e   = a_reg[ELEM_W*int'(idx) +: ELEM_W];
    assign b_e   = b_reg[ELEM_W*int'(idx) +: ELEM_W];

    addsub_elem #(.W(ELEM_W)) u_elem (
        .a   (a_e),
        .b   (b_e),
        .add (op),
        .res (res),
        .ovf (elem_ovf)
    );

    // A compute runs 16 element edges, then one more edge (full set) to publish the shadow.
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? (addRW ? LOAD : CALC) : IDLE;
            LOAD:    next = DONE;
            CALC:    next = !addEN ? IDLE : (full ? DONE : CALC);
            default: next = addEN ? DONE : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            en_q    <= 1'b0;
            idx     <= '0;
            op      <= 1'b0;
            full    <= 1'b0;
            ovf_sh  <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            shadow  <= '0;
            dataOut <= '0;
            addFleg <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state   <= next;
            en_q    <= addEN;
            addFleg <= next == DONE;
            if (state == IDLE && start && addRW) begin
                if (matDecide) b_reg <= dataIn;
                else a_reg <= dataIn;
            end
            if (state == IDLE && start && !addRW) begin
                op     <= add1sub0;
                idx    <= '0;
                full   <= 1'b0;
                ovf_sh <= 1'b0;
            end
            if (state == CALC && addEN && !full) begin
                shadow[ELEM_W*int'(idx) +: ELEM_W] <= res;
                ovf_sh <= ovf_sh | elem_ovf;
                idx    <= idx + 1'b1;
                full   <= idx == IDX_W'(N_ELEM - 1);
            end
            if (state == CALC && addEN && full) begin
                dataOut <= shadow;
                ovf     <= ovf_sh;
            end
        end
    end
endmodule
